// File: rtl/ram_io_responder.sv
// Responder for the byte-wide CPU memory bus: synchronous byte RAM plus a small I/O window
// (TX FIFO, RX holding register, status, sticky halt). Define SIM_TX_DISPLAY_EN to echo TX pushes in simulation.
module ram_io_responder #(
    parameter int unsigned RAM_ADDR_WIDTH = 17,
    parameter logic [31:0] IO_BASE        = 32'h0003_0000,
    parameter int unsigned TX_DEPTH_LOG2  = 4
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic [31:0] mem_a,
    input  logic [7:0]  mem_dout,
    input  logic        mem_wr,
    output logic [7:0]  mem_din,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        halt
);

    localparam int unsigned RAM_DEPTH = 1 << RAM_ADDR_WIDTH;
    localparam int unsigned TX_DEPTH  = 1 << TX_DEPTH_LOG2;
    localparam logic [TX_DEPTH_LOG2:0]   TX_FULL_COUNT = (TX_DEPTH_LOG2 + 1)'(TX_DEPTH);
    localparam logic [TX_DEPTH_LOG2:0]   TX_COUNT_ONE  = (TX_DEPTH_LOG2 + 1)'(1);
    localparam logic [TX_DEPTH_LOG2-1:0] TX_PTR_ONE    = TX_DEPTH_LOG2'(1);

    localparam logic [31:0] OFF_DATA    = 32'h0000_0000;
    localparam logic [31:0] OFF_HALT    = 32'h0000_0004;
    localparam logic [31:0] OFF_STATUS  = 32'h0000_0008;
    localparam logic [31:0] OFF_OVF_CLR = 32'h0000_000C;

    // ---------------- address decode ----------------
    logic                      io;
    logic [31:0]               off;
    logic [RAM_ADDR_WIDTH-1:0] ram_idx;
    logic                      ram_we;
    logic                      io_we;
    logic                      tx_push_req;
    logic                      halt_set;
    logic                      rx_ack;
    logic                      ovf_clr;

    assign io      = (mem_a >= IO_BASE);
    assign off     = mem_a - IO_BASE;
    assign ram_idx = mem_a[RAM_ADDR_WIDTH-1:0];

    assign ram_we      = rdy_in && mem_wr && !io;
    assign io_we       = rdy_in && mem_wr && io;
    assign tx_push_req = io_we && (off == OFF_DATA);
    assign halt_set    = io_we && (off == OFF_HALT);
    assign rx_ack      = io_we && (off == OFF_STATUS);
    assign ovf_clr     = io_we && (off == OFF_OVF_CLR);

    // ---------------- RAM ----------------
    logic [7:0] ram [RAM_DEPTH];

    always_ff @(posedge clk_in) begin
        if (ram_we) begin
            ram[ram_idx] <= mem_dout;
        end
    end

    // ---------------- TX FIFO ----------------
    logic [7:0]               tx_mem [TX_DEPTH];
    logic [TX_DEPTH_LOG2-1:0] tx_head;
    logic [TX_DEPTH_LOG2-1:0] tx_tail;
    logic [TX_DEPTH_LOG2:0]   tx_count;
    logic                     tx_full;
    logic                     tx_pop;
    logic                     tx_push;
    logic                     tx_overflow;

    assign tx_full  = (tx_count == TX_FULL_COUNT);
    assign tx_valid = (tx_count != '0);
    assign tx_data  = tx_valid ? tx_mem[tx_head] : '0;
    assign tx_pop   = tx_valid && tx_ready;
    // A full FIFO still accepts when the head leaves on the same edge
    assign tx_push  = tx_push_req && (!tx_full || tx_pop);

    always_ff @(posedge clk_in) begin
        if (tx_push) begin
            tx_mem[tx_tail] <= mem_dout;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            tx_head     <= '0;
            tx_tail     <= '0;
            tx_count    <= '0;
            tx_overflow <= 1'b0;
        end else begin
            if (tx_pop) begin
                tx_head <= tx_head + TX_PTR_ONE;
            end
            if (tx_push) begin
                tx_tail <= tx_tail + TX_PTR_ONE;
            end
            if (tx_push && !tx_pop) begin
                tx_count <= tx_count + TX_COUNT_ONE;
            end else if (tx_pop && !tx_push) begin
                tx_count <= tx_count - TX_COUNT_ONE;
            end
            if (tx_push_req && tx_full && !tx_pop) begin
                tx_overflow <= 1'b1;
            end else if (ovf_clr) begin
                tx_overflow <= 1'b0;
            end
        end
    end

    // ---------------- RX holding register ----------------
    logic       rx_full;
    logic [7:0] rx_byte;
    logic       rx_capture;

    assign rx_ready   = !rx_full;
    assign rx_capture = rx_valid && !rx_full;

    // Capture needs an empty register and ack of an empty register is a no-op, so they never conflict
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            rx_full <= 1'b0;
            rx_byte <= '0;
        end else if (rx_capture) begin
            rx_full <= 1'b1;
            rx_byte <= rx_data;
        end else if (rx_ack) begin
            rx_full <= 1'b0;
        end
    end

    // ---------------- halt ----------------
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            halt <= 1'b0;
        end else if (halt_set) begin
            halt <= 1'b1;
        end
    end

    // ---------------- read path ----------------
    logic [7:0] io_rd;
    logic [7:0] rd_val;

    always_comb begin
        io_rd = '0;
        if (off == OFF_DATA) begin
            io_rd = rx_full ? rx_byte : '0;
        end else if (off == OFF_STATUS) begin
            io_rd = {5'b0, tx_overflow, rx_full, tx_full};
        end
    end

    assign rd_val = io ? io_rd : ram[ram_idx];

    // Sampled before this edge's RAM write lands, giving read-before-write on collisions
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            mem_din <= '0;
        end else if (rdy_in) begin
            mem_din <= rd_val;
        end
    end

`ifdef SIM_TX_DISPLAY_EN
    always_ff @(posedge clk_in) begin
        if (tx_push) begin
            $write("%c", mem_dout);
        end
    end
`else
    // No simulation console echo in the default build
`endif

endmodule

// File: tb/tb_ram_io_responder.sv
// Self-checking bench for ram_io_responder: directed scenarios plus randomized traffic
// compared against a queue/array reference model of the bus, TX FIFO, RX register and halt.
module tb_ram_io_responder;

    localparam logic [31:0] IO_BASE = 32'h0003_0000;
    localparam logic [31:0] IDLE_A  = 32'h0003_0100;
    localparam int          DEPTH   = 16;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic [31:0] mem_a;
    logic [7:0]  mem_dout;
    logic        mem_wr;
    logic [7:0]  mem_din;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        halt;

    int checks = 0;
    int errors = 0;

    ram_io_responder #(
        .RAM_ADDR_WIDTH(17),
        .IO_BASE(32'h0003_0000),
        .TX_DEPTH_LOG2(4)
    ) dut (
        .clk_in(clk_in),
        .rst_in(rst_in),
        .rdy_in(rdy_in),
        .mem_a(mem_a),
        .mem_dout(mem_dout),
        .mem_wr(mem_wr),
        .mem_din(mem_din),
        .tx_data(tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .rx_ready(rx_ready),
        .halt(halt)
    );

    always #5 clk_in = ~clk_in;

    // ---------------- reference model ----------------
    logic [7:0] m_ram [int unsigned];
    logic [7:0] m_txq [$];
    bit         m_rx_full;
    logic [7:0] m_rx_byte;
    bit         m_ovf;
    bit         m_halt;
    logic [7:0] m_din;
    bit         m_din_known;

    task automatic model_reset();
        m_txq.delete();
        m_rx_full   = 0;
        m_rx_byte   = 8'h00;
        m_ovf       = 0;
        m_halt      = 0;
        m_din       = 8'h00;
        m_din_known = 1;
    endtask

    // Advance the model by one rising edge using the inputs currently driven, then move to edge+1
    task automatic cycle();
        bit          io;
        logic [31:0] off;
        int unsigned idx;
        bit          pop;
        bit          cap;
        bit          ack;
        logic [7:0]  rd;
        io  = (mem_a >= IO_BASE);
        off = mem_a - IO_BASE;
        idx = mem_a % 32'h0002_0000;
        pop = (m_txq.size() != 0) && tx_ready;
        cap = rx_valid && !m_rx_full;
        ack = 0;
        rd  = 8'h00;
        if (rdy_in) begin
            if (io) begin
                m_din_known = 1;
                if (off == 0) rd = m_rx_full ? m_rx_byte : 8'h00;
                else if (off == 8) rd = {5'b0, m_ovf, m_rx_full, (m_txq.size() == DEPTH)};
            end else if (m_ram.exists(idx)) begin
                m_din_known = 1;
                rd = m_ram[idx];
            end else begin
                m_din_known = 0;
            end
            m_din = rd;
        end
        if (pop) void'(m_txq.pop_front());
        if (rdy_in && mem_wr) begin
            if (!io) m_ram[idx] = mem_dout;
            else if (off == 0) begin
                if (m_txq.size() < DEPTH) m_txq.push_back(mem_dout);
                else m_ovf = 1;
            end
            else if (off == 4)  m_halt = 1;
            else if (off == 8)  ack = 1;
            else if (off == 12) m_ovf = 0;
        end
        if (cap) begin
            m_rx_full = 1;
            m_rx_byte = rx_data;
        end else if (ack) begin
            m_rx_full = 0;
        end
        @(posedge clk_in);
        #1;
    endtask

    task automatic set_idle();
        rdy_in   = 1'b1;
        mem_wr   = 1'b0;
        mem_a    = IDLE_A;
        mem_dout = 8'h00;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [7:0] d);
        rdy_in   = 1'b1;
        mem_wr   = 1'b1;
        mem_a    = a;
        mem_dout = d;
        cycle();
        set_idle();
    endtask

    // Address held for two edges; value returned is what is visible after the first
    task automatic bus_read(input logic [31:0] a, output logic [7:0] v);
        rdy_in = 1'b1;
        mem_wr = 1'b0;
        mem_a  = a;
        cycle();
        v = mem_din;
        cycle();
        set_idle();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_in   = 1'b0;
        set_idle();
        tx_ready = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        model_reset();
        repeat (2) @(posedge clk_in);
        #1;
        checks++; if (mem_din !== 8'h00) begin errors++; $display("FAIL reset_mem_din got %h expected 00", mem_din); end
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_valid got %b expected 0", tx_valid); end
        checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data got %h expected 00", tx_data); end
        checks++; if (rx_ready !== 1'b1) begin errors++; $display("FAIL reset_rx_ready got %b expected 1", rx_ready); end
        checks++; if (halt !== 1'b0) begin errors++; $display("FAIL reset_halt got %b expected 0", halt); end
        rst_in = 1'b1;
        cycle();
    endtask

    task automatic test_ram();
        logic [7:0] v;
        bus_write(32'h0000_0010, 8'hA5);
        bus_read(32'h0000_0010, v);
        checks++; if (v !== 8'hA5) begin errors++; $display("FAIL ram_read got %h expected a5", v); end
        bus_write(32'h0002_0010, 8'h3C);
        bus_read(32'h0000_0010, v);
        checks++; if (v !== 8'h3C) begin errors++; $display("FAIL ram_alias got %h expected 3c", v); end
        mem_a = 32'h0000_0010; mem_wr = 1'b1; mem_dout = 8'h5A;
        cycle();
        checks++; if (mem_din !== 8'h3C) begin errors++; $display("FAIL ram_rbw got %h expected 3c", mem_din); end
        mem_wr = 1'b0;
        cycle();
        checks++; if (mem_din !== 8'h5A) begin errors++; $display("FAIL ram_after_write got %h expected 5a", mem_din); end
        set_idle();
        cycle();
    endtask

    task automatic test_rdy();
        logic [7:0] v;
        bus_write(32'h0000_0020, 8'h11);
        cycle();
        checks++; if (mem_din !== 8'h00) begin errors++; $display("FAIL rdy_pre_din got %h expected 00", mem_din); end
        rdy_in = 1'b0; mem_wr = 1'b1; mem_a = 32'h0000_0020; mem_dout = 8'h77;
        repeat (3) cycle();
        checks++; if (mem_din !== 8'h00) begin errors++; $display("FAIL rdy_hold_din got %h expected 00", mem_din); end
        bus_read(32'h0000_0020, v);
        checks++; if (v !== 8'h11) begin errors++; $display("FAIL rdy_no_write got %h expected 11", v); end
        rdy_in = 1'b0; mem_wr = 1'b1; mem_a = 32'h0000_0020; mem_dout = 8'h77;
        cycle();
        rdy_in = 1'b1;
        cycle();
        checks++; if (mem_din !== 8'h11) begin errors++; $display("FAIL rdy_rbw got %h expected 11", mem_din); end
        set_idle();
        bus_read(32'h0000_0020, v);
        checks++; if (v !== 8'h77) begin errors++; $display("FAIL rdy_write_after got %h expected 77", v); end
    endtask

    task automatic test_tx_overflow();
        logic [7:0] sent [17];
        logic [7:0] v;
        tx_ready = 1'b0;
        for (int i = 0; i < 17; i++) begin
            sent[i] = 8'($urandom);
            bus_write(IO_BASE, sent[i]);
        end
        checks++; if (tx_valid !== 1'b1) begin errors++; $display("FAIL ovf_tx_valid got %b expected 1", tx_valid); end
        bus_read(IO_BASE + 32'h8, v);
        checks++; if (v !== 8'h05) begin errors++; $display("FAIL ovf_status got %h expected 05", v); end
        tx_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (tx_valid !== 1'b1 || tx_data !== sent[i]) begin
                errors++; $display("FAIL ovf_drain[%0d] got valid=%b data=%h expected valid=1 data=%h", i, tx_valid, tx_data, sent[i]);
            end
            cycle();
        end
        checks++; if (tx_valid !== 1'b0 || tx_data !== 8'h00) begin errors++; $display("FAIL ovf_empty got valid=%b data=%h expected 0/00", tx_valid, tx_data); end
        tx_ready = 1'b0;
        bus_read(IO_BASE + 32'h8, v);
        checks++; if (v !== 8'h04) begin errors++; $display("FAIL ovf_sticky got %h expected 04", v); end
        bus_write(IO_BASE + 32'hC, 8'h00);
        bus_read(IO_BASE + 32'h8, v);
        checks++; if (v !== 8'h00) begin errors++; $display("FAIL ovf_clear got %h expected 00", v); end
    endtask

    task automatic test_full_push_pop();
        logic [7:0] sent [17];
        logic [7:0] v;
        tx_ready = 1'b0;
        for (int i = 0; i < 17; i++) sent[i] = 8'($urandom);
        for (int i = 0; i < 16; i++) bus_write(IO_BASE, sent[i]);
        bus_read(IO_BASE + 32'h8, v);
        checks++; if (v !== 8'h01) begin errors++; $display("FAIL fpp_full got %h expected 01", v); end
        tx_ready = 1'b1;
        rdy_in = 1'b1; mem_wr = 1'b1; mem_a = IO_BASE; mem_dout = sent[16];
        cycle();
        tx_ready = 1'b0;
        set_idle();
        bus_read(IO_BASE + 32'h8, v);
        checks++; if (v !== 8'h01) begin errors++; $display("FAIL fpp_status got %h expected 01", v); end
        tx_ready = 1'b1;
        for (int i = 1; i < 17; i++) begin
            checks++;
            if (tx_valid !== 1'b1 || tx_data !== sent[i]) begin
                errors++; $display("FAIL fpp_drain[%0d] got valid=%b data=%h expected valid=1 data=%h", i, tx_valid, tx_data, sent[i]);
            end
            cycle();
        end
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL fpp_empty got %b expected 0", tx_valid); end
        tx_ready = 1'b0;
    endtask

    task automatic test_rx_halt();
        logic [7:0] v;
        rx_data = 8'h42; rx_valid = 1'b1;
        cycle();
        rx_valid = 1'b0;
        checks++; if (rx_ready !== 1'b0) begin errors++; $display("FAIL rx_full got rx_ready=%b expected 0", rx_ready); end
        bus_read(IO_BASE, v);
        checks++; if (v !== 8'h42) begin errors++; $display("FAIL rx_read1 got %h expected 42", v); end
        bus_read(IO_BASE, v);
        checks++; if (v !== 8'h42) begin errors++; $display("FAIL rx_read2 got %h expected 42", v); end
        bus_write(IO_BASE + 32'h8, 8'h00);
        checks++; if (rx_ready !== 1'b1) begin errors++; $display("FAIL rx_ack got rx_ready=%b expected 1", rx_ready); end
        bus_read(IO_BASE, v);
        checks++; if (v !== 8'h00) begin errors++; $display("FAIL rx_empty_read got %h expected 00", v); end
        checks++; if (halt !== 1'b0) begin errors++; $display("FAIL halt_pre got %b expected 0", halt); end
        bus_write(IO_BASE + 32'h4, 8'h00);
        checks++; if (halt !== 1'b1) begin errors++; $display("FAIL halt_set got %b expected 1", halt); end
        repeat (5) cycle();
        checks++; if (halt !== 1'b1) begin errors++; $display("FAIL halt_sticky got %b expected 1", halt); end
    endtask

    task automatic test_random();
        logic [31:0] offs [6];
        offs[0] = 32'h0; offs[1] = 32'h4; offs[2] = 32'h8;
        offs[3] = 32'hC; offs[4] = 32'h10; offs[5] = 32'h14;
        for (int i = 0; i < 16; i++) bus_write(32'h0000_0100 + 32'(i), 8'($urandom));
        for (int n = 0; n < 3000; n++) begin
            rdy_in   = ($urandom_range(0, 9) != 0);
            mem_wr   = $urandom_range(0, 1) == 1;
            mem_dout = 8'($urandom);
            if ($urandom_range(0, 1) == 1)
                mem_a = 32'h0000_0100 + 32'($urandom_range(0, 15)) + 32'h0001_0000 * 32'($urandom_range(0, 2));
            else
                mem_a = IO_BASE + offs[$urandom_range(0, 5)];
            tx_ready = ($urandom_range(0, 2) == 0);
            rx_valid = ($urandom_range(0, 3) == 0);
            rx_data  = 8'($urandom);
            cycle();
            if (m_din_known) begin
                checks++; if (mem_din !== m_din) begin errors++; $display("FAIL rand_mem_din cycle %0d got %h expected %h", n, mem_din, m_din); end
            end
            checks++; if (tx_valid !== (m_txq.size() != 0)) begin errors++; $display("FAIL rand_tx_valid cycle %0d got %b expected %b", n, tx_valid, m_txq.size() != 0); end
            if (m_txq.size() != 0) begin
                checks++; if (tx_data !== m_txq[0]) begin errors++; $display("FAIL rand_tx_data cycle %0d got %h expected %h", n, tx_data, m_txq[0]); end
            end else begin
                checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL rand_tx_data cycle %0d got %h expected 00", n, tx_data); end
            end
            checks++; if (rx_ready !== !m_rx_full) begin errors++; $display("FAIL rand_rx_ready cycle %0d got %b expected %b", n, rx_ready, !m_rx_full); end
            checks++; if (halt !== m_halt) begin errors++; $display("FAIL rand_halt cycle %0d got %b expected %b", n, halt, m_halt); end
        end
        set_idle();
        rx_valid = 1'b0;
        tx_ready = 1'b0;
        cycle();
    endtask

    task automatic test_reset_midrun();
        logic [7:0] v;
        tx_ready = 1'b1;
        repeat (20) cycle();
        tx_ready = 1'b0;
        bus_write(IO_BASE + 32'h8, 8'h00);
        for (int i = 0; i < 3; i++) bus_write(IO_BASE, 8'h61 + 8'(i));
        rx_data = 8'h99; rx_valid = 1'b1;
        cycle();
        rx_valid = 1'b0;
        bus_write(32'h0000_0010, 8'h5A);
        bus_read(32'h0000_0010, v);
        checks++;
        if (tx_valid !== 1'b1 || rx_ready !== 1'b0 || mem_din !== 8'h5A) begin
            errors++; $display("FAIL midrun_pre got tx_valid=%b rx_ready=%b mem_din=%h expected 1/0/5a", tx_valid, rx_ready, mem_din);
        end
        #2;
        rst_in = 1'b0;
        #1;
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL midrun_tx_valid got %b expected 0", tx_valid); end
        checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL midrun_tx_data got %h expected 00", tx_data); end
        checks++; if (rx_ready !== 1'b1) begin errors++; $display("FAIL midrun_rx_ready got %b expected 1", rx_ready); end
        checks++; if (halt !== 1'b0) begin errors++; $display("FAIL midrun_halt got %b expected 0", halt); end
        checks++; if (mem_din !== 8'h00) begin errors++; $display("FAIL midrun_mem_din got %h expected 00", mem_din); end
        model_reset();
        @(posedge clk_in);
        #1;
        rst_in = 1'b1;
        bus_read(32'h0000_0010, v);
        checks++; if (v !== 8'h5A) begin errors++; $display("FAIL midrun_ram_kept got %h expected 5a", v); end
    endtask

    initial begin
        test_reset();
        test_ram();
        test_rdy();
        test_tx_overflow();
        test_full_push_pop();
        test_rx_halt();
        test_random();
        test_reset_midrun();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
